// File: rtl/alu_sequencer.sv
// ALU sequencer: accepts one command at a time and steps an external ALU.
// It holds the AC/DR registers and the status flags, and repeats single-bit
// shifts for a multi-bit shift count.
module alu_sequencer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [3:0]   cmd_cnt,
  input  logic [W-1:0] cmd_data,
  output logic [W-1:0] alu_ac,
  output logic [W-1:0] alu_dr,
  output logic [2:0]   alu_op,
  output logic         alu_e,
  input  logic [W-1:0] alu_res,
  input  logic         alu_co,
  input  logic         alu_ovf,
  output logic [W-1:0] ac_out,
  output logic         co,
  output logic         ovf,
  output logic         n,
  output logic         z,
  output logic         done,
  output logic         err
);

  localparam logic [2:0] OP_SHR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_CLA = 3'd6;
  localparam logic [2:0] OP_ILL = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] ac_q, ac_d;
  logic [W-1:0] dr_q, dr_d;
  logic [2:0]   op_q, op_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         co_q, co_d;
  logic         ovf_q, ovf_d;
  logic         n_q, n_d;
  logic         z_q, z_d;

  logic cmd_is_shift;
  logic op_is_shift;

  assign cmd_is_shift = (cmd_op == OP_SHR) || (cmd_op == OP_SHL);
  assign op_is_shift  = (op_q == OP_SHR) || (op_q == OP_SHL);

  // Next-state and datapath: accept in IDLE, update AC/flags in EXEC, pulse in DONE.
  always_comb begin
    state_d = state_q;
    ac_d    = ac_q;
    dr_d    = dr_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    n_d     = n_q;
    z_d     = z_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          dr_d  = cmd_data;
          op_d  = cmd_op;
          cnt_d = cmd_cnt;
          // Illegal ops and zero-length shifts have no work to do.
          if ((cmd_op == OP_ILL) || (cmd_is_shift && (cmd_cnt == 4'd0))) begin
            state_d = DONE;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (op_q == OP_CLA) begin
          ac_d    = '0;
          co_d    = 1'b0;
          ovf_d   = 1'b0;
          n_d     = 1'b0;
          z_d     = 1'b1;
          state_d = DONE;
        end else begin
          // N and Z come from the result itself, not from the ALU's own flags.
          ac_d  = alu_res;
          co_d  = alu_co;
          ovf_d = alu_ovf;
          n_d   = alu_res[W-1];
          z_d   = (alu_res == '0);
          if (op_is_shift) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              state_d = DONE;
            end
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and register update; reset overrides any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ac_q    <= '0;
      dr_q    <= '0;
      op_q    <= 3'd0;
      cnt_q   <= 4'd0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      ac_q    <= ac_d;
      dr_q    <= dr_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
      n_q     <= n_d;
      z_q     <= z_d;
    end
  end

  // Outputs decoded from the registered state only.
  always_comb begin
    cmd_ready = (state_q == IDLE);
    done      = (state_q == DONE);
    err       = (state_q == DONE) && (op_q == OP_ILL);
    alu_op    = (state_q == EXEC) ? op_q : 3'd0;
    alu_e     = (state_q == EXEC) && op_is_shift;
    alu_ac    = ac_q;
    alu_dr    = dr_q;
    ac_out    = ac_q;
    co        = co_q;
    ovf       = ovf_q;
    n         = n_q;
    z         = z_q;
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a behavioural ALU drives the ALU
// inputs, and a whole-command reference model predicts AC, flags and timing.
module tb_alu_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [3:0]   cmd_cnt;
  logic [W-1:0] cmd_data;
  logic [W-1:0] alu_ac;
  logic [W-1:0] alu_dr;
  logic [2:0]   alu_op;
  logic         alu_e;
  logic [W-1:0] alu_res;
  logic         alu_co;
  logic         alu_ovf;
  logic [W-1:0] ac_out;
  logic         co, ovf, n, z, done, err;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [W-1:0] m_ac;
  logic         m_co, m_ovf, m_n, m_z;

  always #5 clk = ~clk;

  alu_sequencer #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data),
    .alu_ac(alu_ac), .alu_dr(alu_dr), .alu_op(alu_op), .alu_e(alu_e),
    .alu_res(alu_res), .alu_co(alu_co), .alu_ovf(alu_ovf),
    .ac_out(ac_out), .co(co), .ovf(ovf), .n(n), .z(z),
    .done(done), .err(err)
  );

  // Behavioural single-step ALU
  logic [W:0] add_sum;
  assign add_sum = {1'b0, alu_ac} + {1'b0, alu_dr};

  always_comb begin
    alu_res = '0;
    alu_co  = 1'b0;
    alu_ovf = 1'b0;
    case (alu_op)
      3'd0: begin
        alu_res = add_sum[W-1:0];
        alu_co  = add_sum[W];
        alu_ovf = (alu_ac[W-1] == alu_dr[W-1]) && (add_sum[W-1] != alu_ac[W-1]);
      end
      3'd1: alu_res = alu_ac & alu_dr;
      3'd2: alu_res = alu_dr;
      3'd3: alu_res = ~alu_ac;
      3'd4: if (alu_e) begin alu_res = alu_ac >> 1; alu_co = alu_ac[0]; end
      3'd5: if (alu_e) begin alu_res = alu_ac << 1; alu_co = alu_ac[W-1]; end
      default: ;
    endcase
  end

  task automatic model_reset();
    m_ac = '0; m_co = 1'b0; m_ovf = 1'b0; m_n = 1'b0; m_z = 1'b1;
  endtask

  // Whole-command effect on AC and flags, computed from plain arithmetic.
  task automatic model_apply(input logic [2:0] op, input logic [3:0] cnt, input logic [W-1:0] data);
    int sa, sd, ssum;
    int unsigned usum;
    logic [W-1:0] r;
    int k;
    k = int'(cnt);
    r = m_ac;
    case (op)
      3'd0: begin
        usum  = int'(m_ac) + int'(data);
        sa    = int'($signed(m_ac));
        sd    = int'($signed(data));
        ssum  = sa + sd;
        r     = usum[W-1:0];
        m_co  = (usum > 32'hFFFF);
        m_ovf = (ssum > 32767) || (ssum < -32768);
      end
      3'd1: begin r = m_ac & data; m_co = 1'b0; m_ovf = 1'b0; end
      3'd2: begin r = data;        m_co = 1'b0; m_ovf = 1'b0; end
      3'd3: begin r = ~m_ac;       m_co = 1'b0; m_ovf = 1'b0; end
      3'd4: if (k > 0) begin r = m_ac >> k; m_co = m_ac[k-1];  m_ovf = 1'b0; end
      3'd5: if (k > 0) begin r = m_ac << k; m_co = m_ac[W-k];  m_ovf = 1'b0; end
      3'd6: begin r = '0; m_co = 1'b0; m_ovf = 1'b0; end
      default: ;
    endcase
    if (!(op == 3'd7 || ((op == 3'd4 || op == 3'd5) && k == 0))) begin
      m_ac = r;
      m_n  = r[W-1];
      m_z  = (r == '0);
    end
  endtask

  function automatic int exp_done_lat(input logic [2:0] op, input logic [3:0] cnt);
    if (op == 3'd7) return 1;
    if (op == 3'd4 || op == 3'd5) return (cnt == 4'd0) ? 1 : int'(cnt) + 1;
    return 2;
  endfunction

  function automatic int exp_e_cycles(input logic [2:0] op, input logic [3:0] cnt);
    if (op == 3'd4 || op == 3'd5) return int'(cnt);
    return 0;
  endfunction

  // Drives one command handshake and records what the DUT does afterwards.
  task automatic run_cmd(input logic [2:0] op, input logic [3:0] cnt, input logic [W-1:0] data,
                         output int done_lat, output int ready_lat, output int done_cnt,
                         output int e_cyc, output int op_bad, output logic err_at_done);
    int waited;
    logic [2:0] exp_op;
    done_lat = -1; ready_lat = -1; done_cnt = 0; e_cyc = 0; op_bad = 0; err_at_done = 1'b0;
    waited = 0;
    @(negedge clk);
    while (!cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_cnt = cnt; cmd_data = data;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom);
    cmd_cnt   = 4'($urandom);
    cmd_data  = W'($urandom);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_lat < 0) begin
          done_lat    = i;
          err_at_done = err;
        end
      end
      if (alu_e) e_cyc++;
      exp_op = (done_lat < 0) ? op : 3'd0;
      if (alu_op !== exp_op) op_bad++;
      if (cmd_ready) begin
        ready_lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    @(negedge clk);
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = 3'd2; cmd_cnt = 4'd0; cmd_data = 16'h5555;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; cmd_valid = 1'b0;
    model_reset();
    checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: ready=%b done=%b err=%b, want 1 0 0", cmd_ready, done, err);
    end
    checks++;
    if (ac_out !== 16'h0000 || alu_dr !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_regs: ac=%h dr=%h, want 0000 0000", ac_out, alu_dr);
    end
    checks++;
    if ({co, ovf, n, z} !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL reset_flags: co/ovf/n/z=%b, want 0001", {co, ovf, n, z});
    end
    checks++;
    if (alu_op !== 3'd0 || alu_e !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_alu: alu_op=%0d alu_e=%b, want 0 0", alu_op, alu_e);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b0 || ac_out !== 16'h0000 || cmd_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_cmd_ignored: done=%b ac=%h ready=%b, want 0 0000 1", done, ac_out, cmd_ready);
    end
  endtask

  task automatic test_add_overflow();
    int dl, rl, dc, ec, ob;
    logic e;
    $display("[TB] test_add_overflow");
    run_cmd(3'd2, 4'd0, 16'h7FFF, dl, rl, dc, ec, ob, e);
    model_apply(3'd2, 4'd0, 16'h7FFF);
    checks++;
    if (dl !== 2 || rl !== 3 || ac_out !== 16'h7FFF) begin
      failures++;
      $display("[TB] FAIL lda_7fff: done_lat=%0d ready_lat=%0d ac=%h, want 2 3 7fff", dl, rl, ac_out);
    end
    run_cmd(3'd0, 4'd0, 16'h0001, dl, rl, dc, ec, ob, e);
    model_apply(3'd0, 4'd0, 16'h0001);
    checks++;
    if (dl !== 2 || rl !== 3 || dc !== 1 || ob !== 0) begin
      failures++;
      $display("[TB] FAIL add_timing: done_lat=%0d ready_lat=%0d dones=%0d op_bad=%0d, want 2 3 1 0", dl, rl, dc, ob);
    end
    checks++;
    if (ac_out !== 16'h8000 || {co, ovf, n, z} !== 4'b0110) begin
      failures++;
      $display("[TB] FAIL add_result: ac=%h co/ovf/n/z=%b, want 8000 0110", ac_out, {co, ovf, n, z});
    end
  endtask

  task automatic test_shift_left();
    int dl, rl, dc, ec, ob;
    logic e;
    $display("[TB] test_shift_left");
    run_cmd(3'd2, 4'd0, 16'h0001, dl, rl, dc, ec, ob, e);
    model_apply(3'd2, 4'd0, 16'h0001);
    run_cmd(3'd5, 4'd3, 16'hABCD, dl, rl, dc, ec, ob, e);
    model_apply(3'd5, 4'd3, 16'hABCD);
    checks++;
    if (ec !== 3 || dl !== 4 || rl !== 5 || ob !== 0) begin
      failures++;
      $display("[TB] FAIL shl3_timing: e_cycles=%0d done_lat=%0d ready_lat=%0d op_bad=%0d, want 3 4 5 0", ec, dl, rl, ob);
    end
    checks++;
    if (ac_out !== 16'h0008 || {co, ovf, n, z} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL shl3_result: ac=%h co/ovf/n/z=%b, want 0008 0000", ac_out, {co, ovf, n, z});
    end
  endtask

  task automatic test_shift_zero();
    int dl, rl, dc, ec, ob;
    logic e;
    logic [3:0] flags_before;
    $display("[TB] test_shift_zero");
    run_cmd(3'd2, 4'd0, 16'h00F0, dl, rl, dc, ec, ob, e);
    model_apply(3'd2, 4'd0, 16'h00F0);
    flags_before = {m_co, m_ovf, m_n, m_z};
    run_cmd(3'd4, 4'd0, 16'h0000, dl, rl, dc, ec, ob, e);
    model_apply(3'd4, 4'd0, 16'h0000);
    checks++;
    if (dl !== 1 || rl !== 2 || ec !== 0) begin
      failures++;
      $display("[TB] FAIL shr0_timing: done_lat=%0d ready_lat=%0d e_cycles=%0d, want 1 2 0", dl, rl, ec);
    end
    checks++;
    if (ac_out !== 16'h00F0 || {co, ovf, n, z} !== flags_before) begin
      failures++;
      $display("[TB] FAIL shr0_result: ac=%h flags=%b, want 00f0 %b", ac_out, {co, ovf, n, z}, flags_before);
    end
  endtask

  task automatic test_illegal();
    int dl, rl, dc, ec, ob;
    logic e;
    logic [W-1:0] ac_before;
    $display("[TB] test_illegal");
    ac_before = m_ac;
    run_cmd(3'd7, 4'd5, 16'h1234, dl, rl, dc, ec, ob, e);
    model_apply(3'd7, 4'd5, 16'h1234);
    checks++;
    if (dl !== 1 || e !== 1'b1 || rl !== 2) begin
      failures++;
      $display("[TB] FAIL illegal_err: done_lat=%0d err=%b ready_lat=%0d, want 1 1 2", dl, e, rl);
    end
    checks++;
    if (ac_out !== ac_before || err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL illegal_ac: ac=%h err_after=%b, want %h 0", ac_out, err, ac_before);
    end
  endtask

  task automatic test_reset_mid_exec();
    int dl, rl, dc, ec, ob;
    logic e;
    int stray_done;
    $display("[TB] test_reset_mid_exec");
    run_cmd(3'd2, 4'd0, 16'hFFFF, dl, rl, dc, ec, ob, e);
    model_apply(3'd2, 4'd0, 16'hFFFF);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_cnt = 4'd15; cmd_data = 16'h0000;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    stray_done = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (done) stray_done++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    checks++;
    if (cmd_ready !== 1'b1 || ac_out !== 16'h0000 || {co, ovf, n, z} !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL midexec_reset: ready=%b ac=%h flags=%b, want 1 0000 0001", cmd_ready, ac_out, {co, ovf, n, z});
    end
    checks++;
    if (alu_e !== 1'b0 || alu_op !== 3'd0 || alu_dr !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL midexec_alu: alu_e=%b alu_op=%0d dr=%h, want 0 0 0000", alu_e, alu_op, alu_dr);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) stray_done++;
    end
    checks++;
    if (stray_done !== 0 || ac_out !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL midexec_no_done: done_pulses=%0d ac=%h, want 0 0000", stray_done, ac_out);
    end
  endtask

  task automatic test_back_to_back();
    int dl, rl, dc, ec, ob;
    logic e;
    int hs, dones, done1_cyc, hs2_cyc;
    logic [W-1:0] ac_at_done [2];
    logic z_at_done [2];
    $display("[TB] test_back_to_back");
    run_cmd(3'd2, 4'd0, 16'hFFFF, dl, rl, dc, ec, ob, e);
    model_apply(3'd2, 4'd0, 16'hFFFF);
    hs = 0; dones = 0; done1_cyc = -1; hs2_cyc = -1;
    ac_at_done[0] = 'x; ac_at_done[1] = 'x; z_at_done[0] = 1'bx; z_at_done[1] = 1'bx;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_cnt = 4'd0; cmd_data = 16'h0F0F;
    if (cmd_ready) hs++;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        if (dones < 2) begin
          ac_at_done[dones] = ac_out;
          z_at_done[dones]  = z;
        end
        if (dones == 0) done1_cyc = i;
        dones++;
      end
      if (hs == 1) cmd_op = 3'd6;
      if (hs >= 2) cmd_valid = 1'b0;
      if (cmd_ready && cmd_valid) begin
        hs++;
        if (hs == 2) hs2_cyc = i;
      end
    end
    cmd_valid = 1'b0;
    model_apply(3'd3, 4'd0, 16'h0F0F);
    model_apply(3'd6, 4'd0, 16'h0F0F);
    checks++;
    if (hs !== 2 || dones !== 2) begin
      failures++;
      $display("[TB] FAIL b2b_count: handshakes=%0d done_pulses=%0d, want 2 2", hs, dones);
    end
    checks++;
    if (hs2_cyc !== done1_cyc + 1) begin
      failures++;
      $display("[TB] FAIL b2b_accept_cycle: second accept at %0d, want %0d", hs2_cyc, done1_cyc + 1);
    end
    checks++;
    if (ac_at_done[0] !== 16'h0000 || z_at_done[0] !== 1'b1 || ac_at_done[1] !== 16'h0000 || z_at_done[1] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_results: cma ac=%h z=%b cla ac=%h z=%b, want 0000 1 0000 1",
               ac_at_done[0], z_at_done[0], ac_at_done[1], z_at_done[1]);
    end
  endtask

  task automatic test_random();
    int dl, rl, dc, ec, ob;
    logic e;
    logic [2:0] op;
    logic [3:0] cnt;
    logic [W-1:0] data;
    $display("[TB] test_random");
    for (int t = 0; t < 30; t++) begin
      op   = 3'($urandom_range(0, 7));
      cnt  = 4'($urandom_range(0, 15));
      data = W'($urandom);
      if (t % 5 == 0) data = 16'h8000 | W'($urandom_range(0, 3));
      run_cmd(op, cnt, data, dl, rl, dc, ec, ob, e);
      model_apply(op, cnt, data);
      checks++;
      if (dl !== exp_done_lat(op, cnt) || rl !== exp_done_lat(op, cnt) + 1 || dc !== 1) begin
        failures++;
        $display("[TB] FAIL rand_timing t=%0d op=%0d cnt=%0d: done_lat=%0d ready_lat=%0d dones=%0d, want %0d %0d 1",
                 t, op, cnt, dl, rl, dc, exp_done_lat(op, cnt), exp_done_lat(op, cnt) + 1);
      end
      checks++;
      if (ec !== exp_e_cycles(op, cnt) || ob !== 0 || e !== (op == 3'd7)) begin
        failures++;
        $display("[TB] FAIL rand_ctrl t=%0d op=%0d: e_cycles=%0d op_bad=%0d err=%b, want %0d 0 %b",
                 t, op, ec, ob, e, exp_e_cycles(op, cnt), (op == 3'd7));
      end
      checks++;
      if (ac_out !== m_ac || {co, ovf, n, z} !== {m_co, m_ovf, m_n, m_z}) begin
        failures++;
        $display("[TB] FAIL rand_result t=%0d op=%0d cnt=%0d data=%h: ac=%h flags=%b, want %h %b",
                 t, op, cnt, data, ac_out, {co, ovf, n, z}, m_ac, {m_co, m_ovf, m_n, m_z});
      end
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_cnt = 4'd0; cmd_data = '0;
    model_reset();
    test_reset();
    test_add_overflow();
    test_shift_left();
    test_shift_zero();
    test_illegal();
    test_reset_mid_exec();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
